// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types for the multicycle control unit.
// Holds the phase enum, the opcode map of the 8-opcode ISA and the
// instruction-class enum that the FSM branches on.
package ctrl_pkg;

    // One phase per clock; IDLE is where Done is reported.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5
    } state_t;

    // Opcode map (low three bits of the instruction register).
    localparam int OP_ADD = 0;
    localparam int OP_BEQ = 1;
    localparam int OP_SB  = 2;
    localparam int OP_LBU = 3;
    localparam int OP_XOR = 4;
    localparam int OP_OR  = 5;
    localparam int OP_AND = 6;
    localparam int OP_SRL = 7;

    // Instruction classes: register ALU op, branch, store, load.
    typedef enum logic [1:0] {
        CLS_R  = 2'd0,
        CLS_BR = 2'd1,
        CLS_ST = 2'd2,
        CLS_LD = 2'd3
    } iclass_t;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: maps a latched opcode to its instruction class.
// Any opcode with bits set above bit 2 (only possible when MCW > 3)
// is treated as a register-type ALU instruction.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int MCW = 3
) (
    input  logic [MCW-1:0] op,
    output iclass_t        cls
);

    logic [2:0] op_low;
    logic       upper_nz;

    generate
        if (MCW > 3) begin : g_wide
            assign op_low   = op[2:0];
            assign upper_nz = |op[MCW-1:3];
        end else begin : g_narrow
            assign op_low   = 3'(op);
            assign upper_nz = 1'b0;
        end
    endgenerate

    // Class lookup; everything that is not beq/sb/lbu runs as R-type.
    always_comb begin
        cls = CLS_R;
        if (!upper_nz) begin
            case (op_low)
                3'(OP_BEQ): cls = CLS_BR;
                3'(OP_SB):  cls = CLS_ST;
                3'(OP_LBU): cls = CLS_LD;
                default:    cls = CLS_R;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: sequences each instruction through
// FETCH/DECODE/EXEC/MEM/WB, one phase per clock, and drives the datapath
// strobes. The opcode is captured in DECODE so later changes on instr are
// ignored. Optional macro CTRL_PERF_EN adds InstrCount/StallCount counters.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int              OPW        = 3,
    parameter int              MCW        = 3,
    parameter logic [OPW-1:0]  ALUOP_PASS = {OPW{1'b1}}
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           Start,
    input  logic           Halt,
    input  logic [MCW-1:0] instr,
    input  logic           Zero,
    input  logic           mem_ready,
    output logic           PCWrite,
    output logic           IRWrite,
    output logic           Branch,
    output logic           MemRead,
    output logic           MemWrite,
    output logic           MemtoReg,
    output logic           ALUSrc,
    output logic           RegWrite,
    output logic [OPW-1:0] ALUOp,
    output logic           Done
`ifdef CTRL_PERF_EN
    ,
    output logic [31:0]    InstrCount,
    output logic [31:0]    StallCount
`endif
);

    state_t         state_reg;
    state_t         state_next;
    logic [MCW-1:0] op_reg;
    iclass_t        op_class;

    ctrl_decode #(.MCW(MCW)) u_decode (
        .op  (op_reg),
        .cls (op_class)
    );

    // State and opcode registers; reset wins over any phase, aborting MEM.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= IDLE;
            op_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == DECODE) begin
                op_reg <= instr;
            end
        end
    end

    // Next-phase selection.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (Start) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                state_next = Halt ? IDLE : DECODE;
            end
            DECODE: begin
                state_next = EXEC;
            end
            EXEC: begin
                case (op_class)
                    CLS_BR:         state_next = FETCH;
                    CLS_ST, CLS_LD: state_next = MEM;
                    default:        state_next = WB;
                endcase
            end
            MEM: begin
                // Wait indefinitely for the memory handshake.
                if (mem_ready) begin
                    state_next = (op_class == CLS_LD) ? WB : FETCH;
                end
            end
            WB: begin
                state_next = FETCH;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath strobes decoded from phase and latched opcode.
    always_comb begin
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        Branch   = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemtoReg = 1'b0;
        ALUSrc   = 1'b0;
        RegWrite = 1'b0;
        ALUOp    = ALUOP_PASS;
        Done     = 1'b0;
        case (state_reg)
            IDLE: begin
                Done = 1'b1;
            end
            FETCH: begin
                // A halt request suppresses the instruction fetch entirely.
                if (!Halt) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                end
            end
            EXEC: begin
                ALUOp = OPW'(op_reg);
                if (op_class == CLS_BR) begin
                    Branch  = 1'b1;
                    PCWrite = Zero;
                end
                if (op_class == CLS_ST || op_class == CLS_LD) begin
                    ALUSrc = 1'b1;
                end
            end
            MEM: begin
                MemWrite = (op_class == CLS_ST);
                MemRead  = (op_class == CLS_LD);
            end
            WB: begin
                RegWrite = 1'b1;
                MemtoReg = (op_class == CLS_LD);
            end
            default: begin
            end
        endcase
    end

`ifdef CTRL_PERF_EN
    logic instr_done;
    logic mem_stall;

    assign instr_done = (state_reg == EXEC || state_reg == MEM || state_reg == WB)
                        && (state_next == FETCH);
    assign mem_stall  = (state_reg == MEM) && !mem_ready;

    // Retired-instruction and memory-stall counters; both wrap naturally.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            InstrCount <= '0;
            StallCount <= '0;
        end else begin
            if (instr_done) begin
                InstrCount <= InstrCount + 32'd1;
            end
            if (mem_stall) begin
                StallCount <= StallCount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: self-checking bench for multicycle_control.
// Each instruction is expanded by a behavioural model into a list of
// expected per-cycle strobe sets (one entry per phase), then played
// against the DUT with randomized don't-care inputs.
module tb_multicycle_control;

    localparam int OPW = 3;
    localparam int MCW = 3;
    localparam logic [OPW-1:0] PASS = {OPW{1'b1}};

    typedef struct packed {
        logic           pcw;
        logic           irw;
        logic           br;
        logic           mr;
        logic           mw;
        logic           m2r;
        logic           src;
        logic           rw;
        logic [OPW-1:0] alu;
        logic           done;
    } ctl_t;

    typedef struct {
        ctl_t  exp;
        logic  mr;
        logic  rst;
        string phase;
    } cyc_t;

    logic           clk;
    logic           Reset, Start, Halt, Zero, mem_ready;
    logic [MCW-1:0] instr;
    logic           PCWrite, IRWrite, Branch, MemRead, MemWrite, MemtoReg, ALUSrc, RegWrite;
    logic [OPW-1:0] ALUOp;
    logic           Done;
`ifdef CTRL_PERF_EN
    logic [31:0]    InstrCount, StallCount;
`endif

    ctl_t obs;
    assign obs = {PCWrite, IRWrite, Branch, MemRead, MemWrite, MemtoReg, ALUSrc, RegWrite, ALUOp, Done};

    int checks = 0;
    int fails  = 0;
    int model_instr = 0;
    int model_stall = 0;

    multicycle_control #(.OPW(OPW), .MCW(MCW)) dut (
        .Clk       (clk),
        .Reset     (Reset),
        .Start     (Start),
        .Halt      (Halt),
        .instr     (instr),
        .Zero      (Zero),
        .mem_ready (mem_ready),
        .PCWrite   (PCWrite),
        .IRWrite   (IRWrite),
        .Branch    (Branch),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .MemtoReg  (MemtoReg),
        .ALUSrc    (ALUSrc),
        .RegWrite  (RegWrite),
        .ALUOp     (ALUOp),
        .Done      (Done)
`ifdef CTRL_PERF_EN
        ,
        .InstrCount(InstrCount),
        .StallCount(StallCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ctl_t quiet_vec();
        ctl_t v;
        v = '0;
        v.alu = PASS;
        return v;
    endfunction

    function automatic ctl_t idle_vec();
        ctl_t v;
        v = quiet_vec();
        v.done = 1'b1;
        return v;
    endfunction

    task automatic cycle_begin();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rand();
        Reset     = 1'b0;
        Start     = 1'($urandom);
        Halt      = 1'($urandom);
        Zero      = 1'($urandom);
        mem_ready = 1'($urandom);
        instr     = MCW'($urandom);
    endtask

    task automatic test_reset();
        Reset = 1'b1; Start = 1'b0; Halt = 1'b0; Zero = 1'b0; mem_ready = 1'b0; instr = '0;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (obs !== idle_vec()) begin
            fails++;
            $display("FAIL reset_hold: got %h expected %h", obs, idle_vec());
        end
        model_instr = 0;
        model_stall = 0;
        for (int i = 0; i < 3; i++) begin
            cycle_begin();
            drive_rand();
            Start = 1'b0;
            #1;
            checks++;
            if (obs !== idle_vec()) begin
                fails++;
                $display("FAIL reset_idle%0d: got %h expected %h", i, obs, idle_vec());
            end
        end
`ifdef CTRL_PERF_EN
        checks++;
        if (InstrCount !== 32'd0 || StallCount !== 32'd0) begin
            fails++;
            $display("FAIL reset_counters: got %0d/%0d expected 0/0", InstrCount, StallCount);
        end
`endif
        $display("reset: idle with Done=1");
    endtask

    // IDLE cycle with Start high; the next cycle is FETCH.
    task automatic do_start();
        cycle_begin();
        drive_rand();
        Start = 1'b1;
        #1;
        checks++;
        if (obs !== idle_vec()) begin
            fails++;
            $display("FAIL start_idle: got %h expected %h", obs, idle_vec());
        end
    endtask

    // Play one instruction starting at its FETCH cycle. rst_mem >= 0 asserts
    // Reset during that MEM cycle index, after which IDLE is expected.
    task automatic exec_instr(input logic [MCW-1:0] op, input logic z,
                              input int stalls, input int rst_mem);
        cyc_t q[$];
        ctl_t e;
        int   cls;
        bit   aborted;
        aborted = 1'b0;
        cls = (op == 3'd1) ? 1 : (op == 3'd2) ? 2 : (op == 3'd3) ? 3 : 0;
        e = quiet_vec(); e.pcw = 1'b1; e.irw = 1'b1;
        q.push_back('{e, 1'b0, 1'b0, "FETCH"});
        e = quiet_vec();
        q.push_back('{e, 1'b0, 1'b0, "DECODE"});
        e = quiet_vec(); e.alu = op;
        if (cls == 1) begin e.br = 1'b1; e.pcw = z; end
        if (cls == 2 || cls == 3) e.src = 1'b1;
        q.push_back('{e, 1'b0, 1'b0, "EXEC"});
        if (cls == 2 || cls == 3) begin
            for (int k = 0; k <= stalls; k++) begin
                e = quiet_vec(); e.mw = (cls == 2); e.mr = (cls == 3);
                q.push_back('{e, (k == stalls), (k == rst_mem), "MEM"});
                if (k == rst_mem) begin
                    q.push_back('{idle_vec(), 1'b0, 1'b0, "RST_IDLE"});
                    aborted = 1'b1;
                    break;
                end
            end
        end
        if (!aborted && (cls == 0 || cls == 3)) begin
            e = quiet_vec(); e.rw = 1'b1; e.m2r = (cls == 3);
            q.push_back('{e, 1'b0, 1'b0, "WB"});
        end
        for (int i = 0; i < q.size(); i++) begin
            cycle_begin();
            drive_rand();
            if (i == 0) Halt = 1'b0;
            if (i == 1) instr = op;
            if (i == 2) Zero = z;
            if (q[i].phase == "MEM") mem_ready = q[i].mr;
            if (q[i].phase == "RST_IDLE") Start = 1'b0;
            Reset = q[i].rst;
            #1;
            checks++;
            if (obs !== q[i].exp) begin
                fails++;
                $display("FAIL %s op%0d cyc%0d: got %h expected %h", q[i].phase, op, i, obs, q[i].exp);
            end
        end
        if (aborted) begin
            model_instr = 0;
            model_stall = 0;
        end else begin
            model_instr++;
            model_stall += stalls;
        end
        $display("instr op=%0d zero=%0d stalls=%0d cycles=%0d aborted=%0d", op, z, stalls, q.size(), aborted);
    endtask

    // FETCH with Halt high, then IDLE.
    task automatic test_halt();
        cycle_begin();
        drive_rand();
        Halt = 1'b1;
        #1;
        checks++;
        if (obs !== quiet_vec()) begin
            fails++;
            $display("FAIL halt_fetch: got %h expected %h", obs, quiet_vec());
        end
        cycle_begin();
        drive_rand();
        Start = 1'b0;
        #1;
        checks++;
        if (obs !== idle_vec()) begin
            fails++;
            $display("FAIL halt_idle: got %h expected %h", obs, idle_vec());
        end
`ifdef CTRL_PERF_EN
        checks++;
        if (InstrCount !== 32'(model_instr) || StallCount !== 32'(model_stall)) begin
            fails++;
            $display("FAIL halt_counters: got %0d/%0d expected %0d/%0d",
                     InstrCount, StallCount, model_instr, model_stall);
        end
`endif
        $display("halt: back to idle");
    endtask

    task automatic test_rtype();
        do_start();
        exec_instr(3'd0, 1'b0, 0, -1);
        exec_instr(3'd4, 1'b1, 0, -1);
        test_halt();
    endtask

    task automatic test_beq();
        do_start();
        exec_instr(3'd1, 1'b1, 0, -1);
        exec_instr(3'd1, 1'b0, 0, -1);
        test_halt();
    endtask

    task automatic test_mem();
        do_start();
        exec_instr(3'd2, 1'b0, 3, -1);
        exec_instr(3'd3, 1'b0, 0, -1);
        exec_instr(3'd3, 1'b1, 2, -1);
        test_halt();
    endtask

    task automatic test_reset_mid_mem();
        do_start();
        exec_instr(3'd2, 1'b0, 3, 1);
`ifdef CTRL_PERF_EN
        checks++;
        if (InstrCount !== 32'd0 || StallCount !== 32'd0) begin
            fails++;
            $display("FAIL abort_counters: got %0d/%0d expected 0/0", InstrCount, StallCount);
        end
`endif
        // After the abort the unit must restart cleanly.
        do_start();
        exec_instr(3'd6, 1'b0, 0, -1);
        test_halt();
    endtask

    task automatic test_start_halt();
        cycle_begin();
        drive_rand();
        Start = 1'b1; Halt = 1'b1;
        #1;
        checks++;
        if (obs !== idle_vec()) begin
            fails++;
            $display("FAIL sh_idle: got %h expected %h", obs, idle_vec());
        end
        cycle_begin();
        drive_rand();
        Halt = 1'b1;
        #1;
        checks++;
        if (obs !== quiet_vec()) begin
            fails++;
            $display("FAIL sh_fetch: got %h expected %h", obs, quiet_vec());
        end
        cycle_begin();
        drive_rand();
        Start = 1'b0;
        #1;
        checks++;
        if (obs !== idle_vec()) begin
            fails++;
            $display("FAIL sh_back_idle: got %h expected %h", obs, idle_vec());
        end
        $display("start+halt: one fetch slot, no IRWrite");
    endtask

    task automatic test_random();
        do_start();
        for (int n = 0; n < 40; n++) begin
            exec_instr(MCW'($urandom), 1'($urandom), int'($urandom_range(3, 0)), -1);
            if ($urandom_range(7, 0) == 0) begin
                test_halt();
                do_start();
            end
        end
        test_halt();
    endtask

`ifdef CTRL_PERF_EN
    task automatic test_perf();
        test_reset();
        do_start();
        exec_instr(3'd0, 1'b0, 0, -1);
        exec_instr(3'd2, 1'b0, 2, -1);
        exec_instr(3'd1, 1'b1, 0, -1);
        test_halt();
        checks++;
        if (InstrCount !== 32'd3 || StallCount !== 32'd2) begin
            fails++;
            $display("FAIL perf_fixed: got %0d/%0d expected 3/2", InstrCount, StallCount);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_rtype();
        test_beq();
        test_mem();
        test_reset_mid_mem();
        test_start_halt();
        test_random();
`ifdef CTRL_PERF_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
